load_store_unit: RTL and testbench

//   Sits between the multi-cycle RISC-V datapath and the unified word memory.

---
 rtl/load_store_unit.sv | 176 +++++++++++++++++
 tb/tb_load_store_unit.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Bridges the multi-cycle RISC-V datapath to a unified word-wide memory.
//   Each core request (lb/lh/lw/lbu/lhu/sb/sh/sw) becomes one or more memory
//   cycles. Loads extract the addressed lane and sign/zero-extend it. Because
//   the memory only writes whole words, sb/sh run as read-modify-write.
//   Accesses with a bad funct3, a misaligned address or an out-of-range
//   address are rejected without any memory cycle.
//
// Handshake: req is sampled only while idle (busy=0). Accepting it latches
//   we/funct3/addr/wdata. Exactly one one-cycle done pulse follows, with err
//   qualifying it. req seen while busy is ignored, and there is no queueing.
//   A new request may be presented in the cycle after done.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   req, we       request strobe; 1 = store, 0 = load
//   funct3        0 b, 1 h, 2 w, 4 bu, 5 hu
//   addr, wdata   byte address; store data (low byte/half for sb/sh)
//   rdata         extended load result, held until the next load completes
//   done, err     completion pulse; rejection flag valid with done
//   busy          high whenever the unit is not idle
//   mem_A/WE/WD   word address, write enable and write data to memory
//   mem_RD        combinational read data of mem_A
module load_store_unit #(
  parameter int MEM_WORDS = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic [31:0] mem_A,
  output logic        mem_WE,
  output logic [31:0] mem_WD,
  input  logic [31:0] mem_RD
);

  localparam logic [29:0] MEM_LIMIT = 30'(MEM_WORDS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic        err_q;
  logic [31:0] merge_q;

  // Rejection is decided on the live request inputs, in the cycle req is taken.
  logic bad_funct3;
  logic misaligned;
  logic out_of_range;
  logic reject;

  always_comb begin
    bad_funct3   = (funct3 == 3'd3) || (funct3[2:1] == 2'b11) ||
                   (we && (funct3[2:1] == 2'b10));
    misaligned   = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3 == 3'd2) && (addr[1:0] != 2'b00));
    out_of_range = (addr[31:2] >= MEM_LIMIT);
    reject       = bad_funct3 || misaligned || out_of_range;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (reject)               state_next = DONE;
          else if (!we)             state_next = LOAD;
          else if (funct3 == 3'd2)  state_next = WRITE;
          else                      state_next = RMW_RD;
        end
      end
      LOAD:    state_next = DONE;
      RMW_RD:  state_next = WRITE;
      WRITE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lane extraction for loads (little-endian) and lane merge for sb/sh.
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  always_comb begin
    lane_b    = 8'h00;
    lane_h    = addr_q[1] ? mem_RD[31:16] : mem_RD[15:0];
    load_val  = mem_RD;
    merge_val = mem_RD;
    case (addr_q[1:0])
      2'd0:    lane_b = mem_RD[7:0];
      2'd1:    lane_b = mem_RD[15:8];
      2'd2:    lane_b = mem_RD[23:16];
      default: lane_b = mem_RD[31:24];
    endcase
    case (funct3_q)
      3'd0:    load_val = {{24{lane_b[7]}}, lane_b};
      3'd1:    load_val = {{16{lane_h[15]}}, lane_h};
      3'd4:    load_val = {24'h000000, lane_b};
      3'd5:    load_val = {16'h0000, lane_h};
      default: load_val = mem_RD;
    endcase
    if (funct3_q[1:0] == 2'b00) begin
      case (addr_q[1:0])
        2'd0:    merge_val[7:0]   = wdata_q[7:0];
        2'd1:    merge_val[15:8]  = wdata_q[7:0];
        2'd2:    merge_val[23:16] = wdata_q[7:0];
        default: merge_val[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merge_val[31:16] = wdata_q[15:0];
    end else begin
      merge_val[15:0] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      funct3_q <= 3'd0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      merge_q  <= 32'h0;
      rdata    <= 32'h0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (req) begin
            addr_q   <= addr;
            wdata_q  <= wdata;
            funct3_q <= funct3;
            we_q     <= we;
            err_q    <= reject;
          end
        end
        LOAD:    rdata   <= load_val;
        RMW_RD:  merge_q <= merge_val;
        default: ;
      endcase
    end
  end

  // Outputs; mem_WE is gated by rst so a reset cycle can never write memory.
  always_comb begin
    done   = (state == DONE);
    err    = (state == DONE) && err_q;
    busy   = (state != IDLE);
    mem_A  = {addr_q[31:2], 2'b00};
    mem_WE = (state == WRITE) && !rst;
    mem_WD = 32'h0;
    if (state == WRITE) mem_WD = (funct3_q == 3'd2) ? wdata_q : merge_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Self-checking bench for load_store_unit. A 64-word memory model answers
//   mem_A combinationally and applies mem_WE writes. A behavioural reference
//   (byte-lane arithmetic on a shadow memory) predicts each request's latency,
//   error flag, load result and updated word. One negedge process compares
//   every output every cycle, and a few literal checks pin the reference.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        busy;
  logic [31:0] mem_A;
  logic        mem_WE;
  logic [31:0] mem_WD;
  logic [31:0] mem_RD;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  load_store_unit #(.MEM_WORDS(16384)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err),
    .busy(busy), .mem_A(mem_A), .mem_WE(mem_WE), .mem_WD(mem_WD),
    .mem_RD(mem_RD)
  );

  // ---------------- memory environment ----------------
  logic [31:0] mem [0:63];
  logic        pre_en = 1'b0;
  logic [5:0]  pre_idx = 6'd0;
  logic [31:0] pre_val = 32'h0;
  int          we_cnt = 0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (mem_WE) mem[mem_A[7:2]] <= mem_WD;
    if (mem_WE) we_cnt <= we_cnt + 1;
  end
  assign mem_RD = mem[mem_A[7:2]];

  // ---------------- reference model state ----------------
  logic [31:0] ref_mem [0:63];
  logic [31:0] exp_q[$];
  bit          m_active = 1'b0;
  int          issue_cyc = 0;
  int          m_lat = 0;
  bit          m_err = 1'b0;
  bit          m_we = 1'b0;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_newword = 32'h0;
  logic [31:0] m_rdata = 32'h0;
  int          last_done_k = -1;
  bit          last_err = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  // Behavioural reference: what a request must do, from the ISA rules.
  function automatic void model(input bit w, input logic [2:0] f,
                                input logic [31:0] a, input logic [31:0] d,
                                output bit e, output int lat,
                                output logic [31:0] ld, output logic [31:0] nw);
    logic [31:0] widx;
    logic [31:0] word;
    logic [31:0] v;
    int          size;
    int          sh;
    widx = a >> 2;
    word = (widx < 64) ? ref_mem[widx[5:0]] : 32'h0;
    e    = 1'b0;
    size = 4;
    case (f)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    e = 1'b1;
    endcase
    if (w && f >= 3'd4) e = 1'b1;
    if (size == 2 && (a % 2) != 0) e = 1'b1;
    if (size == 4 && (a % 4) != 0) e = 1'b1;
    if (widx >= 16384) e = 1'b1;
    if (size == 1) sh = 8 * int'(a[1:0]);
    else           sh = a[1] ? 16 : 0;
    if (size == 1) begin
      v = (word >> sh) & 32'hFF;
      if (f == 3'd0 && v >= 128) v = v + 32'hFFFFFF00;
      nw = (word & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
    end else if (size == 2) begin
      v = (word >> sh) & 32'hFFFF;
      if (f == 3'd1 && v >= 32768) v = v + 32'hFFFF0000;
      nw = (word & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
    end else begin
      v  = word;
      nw = d;
    end
    ld  = v;
    lat = e ? 1 : ((w && size < 4) ? 3 : 2);
  endfunction

  // ---------------- driver tasks (called at posedge+2 with DUT idle) ----------------
  task automatic issue(input bit w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    bit          e;
    int          lat;
    logic [31:0] ld;
    logic [31:0] nw;
    model(w, f, a, d, e, lat, ld, nw);
    req = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
    m_active  = 1'b1;
    issue_cyc = cyc;
    m_lat     = lat;
    m_err     = e;
    m_we      = w;
    m_addr    = a;
    m_newword = nw;
    if (!e && !w) exp_q.push_back(ld);
  endtask

  task automatic do_req(input bit w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input bit hold, input bit junk);
    bit got;
    issue(w, f, a, d);
    got = 1'b0;
    last_done_k = -1;
    last_err = 1'b0;
    for (int k = 1; k <= m_lat + 1; k++) begin
      @(posedge clk); #2;
      if (k == m_lat && !m_err) begin
        if (m_we) ref_mem[m_addr[7:2]] = m_newword;
        else if (exp_q.size() > 0) m_rdata = exp_q.pop_front();
      end
      if (done && !got) begin
        got = 1'b1;
        last_done_k = k;
        last_err = err;
      end
      if (k == m_lat + 1) begin
        req = hold;
      end else if (!hold) begin
        if (junk && $urandom_range(0, 1) == 1) begin
          req = 1'b1;
          we = ($urandom_range(0, 1) == 1);
          funct3 = 3'($urandom_range(0, 7));
          addr = $urandom;
          wdata = $urandom;
        end else begin
          req = 1'b0;
        end
      end
    end
  endtask

  // ---------------- per-cycle compare process ----------------
  always @(negedge clk) begin
    bit in_op;
    bit e_done;
    bit e_we;
    if (chk_en) begin
      in_op  = m_active && cyc > issue_cyc && cyc <= issue_cyc + m_lat;
      e_done = m_active && cyc == issue_cyc + m_lat;
      e_we   = m_active && !m_err && m_we && cyc == issue_cyc + m_lat - 1;
      chk1("done", done, e_done);
      chk1("err", err, e_done && m_err);
      chk1("busy", busy, in_op);
      chk1("mem_we", mem_WE, e_we);
      chk("mem_wd", mem_WD, e_we ? m_newword : 32'h0);
      chk("rdata", rdata, m_rdata);
      if (in_op) chk("mem_a", mem_A, {m_addr[31:2], 2'b00});
      if (e_done && !m_err && m_we) chk("mem_word", mem[m_addr[7:2]], m_newword);
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int          we0;
    bit          w;
    bit          hold;
    bit          junk;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] v;

    // Preload memory and shadow while held in reset.
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #2;
      v = $urandom;
      if (i == 2) v = 32'h8899AABB;
      if (i == 5) v = 32'h11223344;
      pre_en = 1'b1; pre_idx = 6'(i); pre_val = v;
      ref_mem[i] = v;
    end
    @(posedge clk); #2;
    pre_en = 1'b0;
    chk("reset_rdata", rdata, 32'h0);
    chk1("reset_done", done, 1'b0);
    chk1("reset_err", err, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_mem_we", mem_WE, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #2;

    // lb / lbu on byte 3 of 0x8899AABB
    do_req(1'b0, 3'd0, 32'h0000000B, 32'h0, 1'b0, 1'b0);
    chk("t1_lb_rdata", rdata, 32'hFFFFFF88);
    chk("t1_lb_model", m_rdata, 32'hFFFFFF88);
    chk("t1_lb_latency", 32'(last_done_k), 32'd2);
    do_req(1'b0, 3'd4, 32'h0000000B, 32'h0, 1'b0, 1'b0);
    chk("t1_lbu_rdata", rdata, 32'h00000088);

    // sh read-modify-write
    we0 = we_cnt;
    do_req(1'b1, 3'd1, 32'h00000008, 32'hABCD1234, 1'b0, 1'b0);
    chk("t2_sh_latency", 32'(last_done_k), 32'd3);
    chk("t2_sh_we_pulses", 32'(we_cnt - we0), 32'd1);
    chk("t2_sh_mem", mem[2], 32'h88991234);
    chk("t2_sh_model", ref_mem[2], 32'h88991234);

    // misaligned sw, out-of-range lw
    we0 = we_cnt;
    do_req(1'b1, 3'd2, 32'h00000006, 32'h12345678, 1'b0, 1'b0);
    chk("t3_sw_mis_latency", 32'(last_done_k), 32'd1);
    chk1("t3_sw_mis_err", last_err, 1'b1);
    do_req(1'b0, 3'd2, 32'h00010000, 32'h0, 1'b0, 1'b0);
    chk1("t3_lw_range_err", last_err, 1'b1);
    chk("t3_no_writes", 32'(we_cnt - we0), 32'd0);

    // invalid funct3 load, sb with funct3=4
    do_req(1'b0, 3'd3, 32'h00000008, 32'h0, 1'b0, 1'b0);
    chk1("t4_f3_err", last_err, 1'b1);
    do_req(1'b1, 3'd4, 32'h00000009, 32'h55, 1'b0, 1'b0);
    chk1("t4_sbu_err", last_err, 1'b1);
    chk("t4_rdata_kept", rdata, 32'h00000088);

    // reset during RMW_RD abandons the sb
    we0 = we_cnt;
    issue(1'b1, 3'd0, 32'h00000015, 32'h000000AA);
    @(posedge clk); #2;
    req = 1'b0;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    m_active = 1'b0;
    exp_q.delete();
    m_rdata = 32'h0;
    chk("t5_mem_unchanged", mem[5], 32'h11223344);
    chk("t5_no_writes", 32'(we_cnt - we0), 32'd0);
    chk("t5_rdata_reset", rdata, 32'h0);
    chk1("t5_busy_reset", busy, 1'b0);
    @(posedge clk); #2;
    do_req(1'b1, 3'd0, 32'h00000015, 32'h000000AA, 1'b0, 1'b0);
    chk("t5_sb_after_reset", mem[5], 32'h1122AA44);

    // back-to-back sw (req held) then lw
    do_req(1'b1, 3'd2, 32'h00000010, 32'hDEADBEEF, 1'b1, 1'b0);
    do_req(1'b0, 3'd2, 32'h00000010, 32'h0, 1'b0, 1'b1);
    chk("t6_lw_rdata", rdata, 32'hDEADBEEF);

    // randomized traffic, with junk req pulses while busy
    for (int n = 0; n < 300; n++) begin
      w    = ($urandom_range(0, 1) == 1);
      f    = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a = $urandom | 32'h00010000;
      else a = 32'($urandom_range(0, 255));
      hold = ($urandom_range(0, 3) == 0);
      junk = ($urandom_range(0, 1) == 1);
      do_req(w, f, a, $urandom, hold, junk);
    end
    req = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
